// File: rtl/passthrough_fifo.sv
// passthrough_fifo: buffers the Passthrough byte stream for a valid/ready
// consumer. The upstream side has no backpressure, so bytes arriving while
// the buffer is full (and no read frees a slot) are dropped and counted.
module passthrough_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_in_valid,
  input  logic [WIDTH-1:0]         io_in_bits,
  output logic                     io_out_valid,
  input  logic                     io_out_ready,
  output logic [WIDTH-1:0]         io_out_bits,
  output logic [$clog2(DEPTH):0]   io_count,
  output logic                     io_full,
  output logic [7:0]               io_dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [7:0]       dropped;

  logic is_full;
  logic rd_en;
  logic wr_en;
  logic drop_en;

  // Occupancy is tracked explicitly; pointer equality is never used for full/empty.
  // A read frees the head slot in the same edge, so a full buffer still
  // accepts a write when the consumer is taking a byte.
  always_comb begin
    is_full = (count == FULL_LVL);
    rd_en   = (count != '0) && io_out_ready;
    wr_en   = io_in_valid && (!is_full || rd_en);
    drop_en = io_in_valid && is_full && !rd_en;
  end

  // Storage array: load the slot at the write pointer on an accepted write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= io_in_bits;
    end
  end

  // Read and write pointers, wrapping naturally modulo DEPTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy count: count + write - read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Dropped-byte counter, saturating so it never wraps back to a small value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dropped <= '0;
    end else if (drop_en && (dropped != 8'hFF)) begin
      dropped <= dropped + 8'd1;
    end
  end

  // Outputs are pure functions of registered state.
  always_comb begin
    io_out_valid = (count != '0);
    io_out_bits  = mem[rd_ptr];
    io_count     = count;
    io_full      = is_full;
    io_dropped   = dropped;
  end

endmodule

// File: tb/tb_passthrough_fifo.sv
// Self-checking bench for passthrough_fifo: a queue-based model is updated on
// every rising edge and compared against the DUT on every falling edge, with
// hand-computed literal checks at key points of each directed scenario.
module tb_passthrough_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             io_in_valid = 1'b0;
  logic [WIDTH-1:0] io_in_bits = '0;
  logic             io_out_valid;
  logic             io_out_ready = 1'b0;
  logic [WIDTH-1:0] io_out_bits;
  logic [2:0]       io_count;
  logic             io_full;
  logic [7:0]       io_dropped;

  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];
  int         m_drop = 0;

  passthrough_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_bits   (io_in_bits),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_bits  (io_out_bits),
    .io_count     (io_count),
    .io_full      (io_full),
    .io_dropped   (io_dropped)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of buffered bytes plus a saturating drop count.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
      m_drop = 0;
    end else begin
      bit took;
      bit was_full;
      took     = (q.size() > 0) && io_out_ready;
      was_full = (q.size() == DEPTH);
      if (took) void'(q.pop_front());
      if (io_in_valid) begin
        if (!was_full || took) q.push_back(io_in_bits);
        else if (m_drop < 255) m_drop++;
      end
    end
  end

  // Compare process: every falling edge outside reset.
  always @(negedge clock) begin
    if (!reset) begin
      chk("m_valid", 32'(io_out_valid), 32'(q.size() != 0));
      chk("m_count", 32'(io_count), 32'(q.size()));
      chk("m_full", 32'(io_full), 32'(q.size() == DEPTH));
      chk("m_dropped", 32'(io_dropped), 32'(m_drop));
      if (q.size() != 0) chk("m_bits", 32'(io_out_bits), 32'(q[0]));
    end
  end

  task automatic cyc(input logic v, input logic [7:0] b, input logic r);
    io_in_valid  = v;
    io_in_bits   = b;
    io_out_ready = r;
    @(negedge clock);
  endtask

  initial begin
    logic [7:0] got[$];
    int sent;
    int n;
    int d0;
    logic r;

    // Reset held for 50 ns, then every output must be zero.
    #50;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(io_out_valid), 32'd0);
    chk("rst_bits", 32'(io_out_bits), 32'd0);
    chk("rst_count", 32'(io_count), 32'd0);
    chk("rst_full", 32'(io_full), 32'd0);
    chk("rst_dropped", 32'(io_dropped), 32'd0);
    @(negedge clock);

    // Streaming with ready held high: output is input delayed by one cycle.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b1);
      chk("stream_bits", 32'(io_out_bits), 32'(i));
      chk("stream_valid", 32'(io_out_valid), 32'd1);
      chk("stream_count", 32'(io_count), 32'd1);
      chk("stream_dropped", 32'(io_dropped), 32'd0);
    end
    cyc(1'b0, 8'h00, 1'b1);
    chk("stream_empty", 32'(io_count), 32'd0);

    // Fill and drop: six writes into a four-entry buffer.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 8'(8'h10 + i), 1'b0);
      if (i == 3) chk("fill_full4", 32'(io_full), 32'd1);
    end
    chk("fill_count", 32'(io_count), 32'd4);
    chk("fill_dropped", 32'(io_dropped), 32'd2);
    for (int i = 0; i < 4; i++) begin
      chk("drain_bits", 32'(io_out_bits), 32'(8'h10 + i));
      cyc(1'b0, 8'h00, 1'b1);
    end
    chk("drain_count", 32'(io_count), 32'd0);
    chk("drain_valid", 32'(io_out_valid), 32'd0);

    // Full buffer with simultaneous read and write for 10 cycles.
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'(8'h30 + i), 1'b1);
      chk("fullrw_count", 32'(io_count), 32'd4);
      chk("fullrw_dropped", 32'(io_dropped), 32'd2);
    end
    chk("fullrw_head", 32'(io_out_bits), 32'h36);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("fullrw_empty", 32'(io_count), 32'd0);

    // Wrap-around: 20 bytes, ready toggling, 3-cycle input gap every 5 bytes.
    sent = 0;
    n    = 0;
    d0   = m_drop;
    r    = 1'b1;
    got.delete();
    while ((sent < 20 || q.size() != 0) && n < 200) begin
      logic v;
      v = (sent < 20) && ((n % 8) < 5);
      if (io_out_valid && r) got.push_back(io_out_bits);
      cyc(v, 8'(8'h40 + sent), r);
      if (v) sent++;
      r = ~r;
      n++;
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL wrap_timeout: got %0d cycles expected under 200", n);
    end
    chk("wrap_conserved", 32'(got.size() + (m_drop - d0)), 32'd20);
    chk("wrap_first", 32'(got[0]), 32'h40);
    for (int k = 1; k < got.size(); k++) begin
      chk("wrap_order", 32'(got[k] > got[k-1]), 32'd1);
    end
    cyc(1'b0, 8'h00, 1'b0);

    // Drop saturation: ready low, valid high for 300 cycles.
    for (int i = 0; i < 300; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0);
    chk("sat_dropped", 32'(io_dropped), 32'd255);
    chk("sat_head", 32'(io_out_bits), 32'h50);
    chk("sat_count", 32'(io_count), 32'd4);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'hEE, 1'b0);
    chk("sat_hold", 32'(io_dropped), 32'd255);

    // Mid-stream reset at count 3: clears without waiting for an edge.
    cyc(1'b0, 8'h00, 1'b1);
    chk("pre_rst_count", 32'(io_count), 32'd3);
    io_out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_count", 32'(io_count), 32'd0);
    chk("midrst_valid", 32'(io_out_valid), 32'd0);
    chk("midrst_dropped", 32'(io_dropped), 32'd0);
    chk("midrst_full", 32'(io_full), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    cyc(1'b1, 8'h77, 1'b0);
    chk("post_rst_bits", 32'(io_out_bits), 32'h77);
    chk("post_rst_count", 32'(io_count), 32'd1);
    cyc(1'b0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
